approx_mul_err_monitor: RTL and testbench

Downstream error-metric stage for the approximate 8x8 Dadda multipliers (DT_8_8_*_approx_fa_*). It takes operand pairs and the product the approximate multiplier under test returns for them. It computes the exact product internally and accumulates absolute-error statistics over a programmed number of samples. The run-time statistics give MAE and worst-case error, which we check against the formally derived bounds.

---
 rtl/approx_mul_err_monitor.sv | 260 ++++++++++++++++++++++++++
 tb/tb_approx_mul_err_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_monitor.sv
// ---------------------------------------------------------------------------
// approx_mul_err_monitor
//
// Error-metric stage for approximate WIDTHxWIDTH multipliers. Each accepted
// sample carries an operand pair and the product that the approximate
// multiplier returned for it. The monitor computes the exact product and
// accumulates absolute-error statistics over a programmed number of samples.
// These are the sample count, the count of samples with nonzero error, a
// saturating sum of |err| and the maximum |err|.
//
// Pipeline: S1 (capture) -> S2 (exact product, |err|) -> S3 (statistics).
// A sample accepted at edge t is visible in the statistics after edge t+2.
//
// Optional build macro: ERR_MON_WORST_CAPTURE_EN
//   When defined, the operands and approximate product of the sample that
//   holds the strict maximum |err| are exposed on worst_a / worst_b /
//   worst_approx. Ties keep the earliest sample.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a run (honoured only in IDLE or DONE)
//   num_samples     sample target, latched on an accepted start
//   in_valid        op_a / op_b / approx_prod valid
//   in_ready        monitor accepts a sample this cycle
//   op_a, op_b      operands
//   approx_prod     approximate product for op_a * op_b
//   busy            high in RUN and DRAIN
//   done            high in DONE, held until the next accepted start
//   sample_cnt      samples accumulated
//   err_cnt         samples with nonzero error
//   sum_abs_err     saturating sum of |exact - approx|
//   max_abs_err     largest |exact - approx|
//   sat             sticky flag: sum_abs_err saturated
//   worst_*         (macro only) sample holding the maximum error
// ---------------------------------------------------------------------------
module approx_mul_err_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 17,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [2*WIDTH-1:0]   approx_prod,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [ACC_W-1:0]     sum_abs_err,
  output logic [2*WIDTH-1:0]   max_abs_err,
  output logic                 sat
`ifdef ERR_MON_WORST_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]     worst_a,
  output logic [WIDTH-1:0]     worst_b,
  output logic [2*WIDTH-1:0]   worst_approx
`endif
);

  localparam int PW = 2 * WIDTH;
  // The sum adder is wide enough for both operands plus a carry, so
  // overflow past ACC_W bits shows up in the bits above ACC_W-1.
  localparam int EXT_W = ((ACC_W > PW) ? ACC_W : PW) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Control state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;   // samples accepted at the input

  // Statistics
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [PW-1:0]    max_q, max_d;
  logic             sat_q, sat_d;

  // Pipeline
  logic             s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [PW-1:0]    s1_approx_q;
  logic [PW-1:0]    s2_abs_err_q;

  logic             accept;
  logic [PW-1:0]    exact;
  logic [PW-1:0]    abs_err;
  logic [EXT_W-1:0] sum_ext;

`ifdef ERR_MON_WORST_CAPTURE_EN
  logic [WIDTH-1:0] s2_a_q, s2_b_q;
  logic [PW-1:0]    s2_approx_q;
  logic [WIDTH-1:0] worst_a_q, worst_a_d;
  logic [WIDTH-1:0] worst_b_q, worst_b_d;
  logic [PW-1:0]    worst_approx_q, worst_approx_d;
`endif

  assign in_ready = (state_q == ST_RUN) && (acc_cnt_q < target_q);
  assign accept   = in_valid && in_ready;

  // S2 arithmetic: operands are widened so the product keeps all 2*WIDTH bits.
  assign exact   = PW'(s1_a_q) * PW'(s1_b_q);
  assign abs_err = (exact >= s1_approx_q) ? (exact - s1_approx_q)
                                          : (s1_approx_q - exact);
  assign sum_ext = EXT_W'(sum_q) + EXT_W'(s2_abs_err_q);

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned; a missing default in always_comb infers a latch.
    state_d      = state_q;
    target_d     = target_q;
    acc_cnt_d    = acc_cnt_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    sum_d        = sum_q;
    max_d        = max_q;
    sat_d        = sat_q;
`ifdef ERR_MON_WORST_CAPTURE_EN
    worst_a_d      = worst_a_q;
    worst_b_d      = worst_b_q;
    worst_approx_d = worst_approx_q;
`endif

    // S3: fold one finished sample into the statistics.
    if (s2_valid_q) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (s2_abs_err_q != '0) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      // Strictly greater, so a tie keeps the earlier sample.
      if (s2_abs_err_q > max_q) begin
        max_d = s2_abs_err_q;
`ifdef ERR_MON_WORST_CAPTURE_EN
        worst_a_d      = s2_a_q;
        worst_b_d      = s2_b_q;
        worst_approx_d = s2_approx_q;
`endif
      end
      if (sum_ext[EXT_W-1:ACC_W] != '0) begin
        sum_d = '1;
        sat_d = 1'b1;
      end else begin
        sum_d = sum_ext[ACC_W-1:0];
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // The pipeline is empty here, so clearing overrides nothing live.
          target_d     = num_samples;
          acc_cnt_d    = '0;
          sample_cnt_d = '0;
          err_cnt_d    = '0;
          sum_d        = '0;
          max_d        = '0;
          sat_d        = 1'b0;
`ifdef ERR_MON_WORST_CAPTURE_EN
          worst_a_d      = '0;
          worst_b_d      = '0;
          worst_approx_d = '0;
`endif
          state_d = (num_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          // target_q is nonzero in RUN, so target_q - 1 cannot underflow.
          if (acc_cnt_q == target_q - CNT_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, statistics and valid bits: synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register
    // samples the pre-edge value of every other register.
    if (rst) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      acc_cnt_q    <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_q        <= '0;
      max_q        <= '0;
      sat_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
`ifdef ERR_MON_WORST_CAPTURE_EN
      worst_a_q      <= '0;
      worst_b_q      <= '0;
      worst_approx_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      acc_cnt_q    <= acc_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sum_q        <= sum_d;
      max_q        <= max_d;
      sat_q        <= sat_d;
      s1_valid_q   <= accept;
      s2_valid_q   <= s1_valid_q;
`ifdef ERR_MON_WORST_CAPTURE_EN
      worst_a_q      <= worst_a_d;
      worst_b_q      <= worst_b_d;
      worst_approx_q <= worst_approx_d;
`endif
    end
  end

  // NOTE: pipeline payload registers are not reset. Their valid bits are,
  // and nothing reads the payload unless the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_q      <= op_a;
      s1_b_q      <= op_b;
      s1_approx_q <= approx_prod;
    end
    s2_abs_err_q <= abs_err;
`ifdef ERR_MON_WORST_CAPTURE_EN
    s2_a_q      <= s1_a_q;
    s2_b_q      <= s1_b_q;
    s2_approx_q <= s1_approx_q;
`endif
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign sum_abs_err = sum_q;
  assign max_abs_err = max_q;
  assign sat         = sat_q;
`ifdef ERR_MON_WORST_CAPTURE_EN
  assign worst_a      = worst_a_q;
  assign worst_b      = worst_b_q;
  assign worst_approx = worst_approx_q;
`endif

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_approx_mul_err_monitor
//
// Directed bench for approx_mul_err_monitor. Two instances share all inputs:
// u_dut uses the default ACC_W=32, and u_sat uses ACC_W=8 to exercise sum
// saturation. Inputs are driven 1 time unit after each rising edge, and
// outputs are sampled at the same point.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_approx_mul_err_monitor;

  localparam int WIDTH = 8;
  localparam int CNT_W = 17;
  localparam int PW    = 2 * WIDTH;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic [WIDTH-1:0] op_a, op_b;
  logic [PW-1:0]    approx_prod;

  logic             in_ready, busy, done, sat;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [31:0]      sum_abs_err;
  logic [PW-1:0]    max_abs_err;

  logic             s_in_ready, s_busy, s_done, s_sat;
  logic [CNT_W-1:0] s_sample_cnt, s_err_cnt;
  logic [7:0]       s_sum_abs_err;
  logic [PW-1:0]    s_max_abs_err;

`ifdef ERR_MON_WORST_CAPTURE_EN
  logic [WIDTH-1:0] worst_a, worst_b, s_worst_a, s_worst_b;
  logic [PW-1:0]    worst_approx, s_worst_approx;
`endif

  int checks = 0;
  int errors = 0;

  approx_mul_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
    .approx_prod(approx_prod), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err), .sat(sat)
`ifdef ERR_MON_WORST_CAPTURE_EN
    , .worst_a(worst_a), .worst_b(worst_b), .worst_approx(worst_approx)
`endif
  );

  approx_mul_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(8)) u_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .op_a(op_a), .op_b(op_b),
    .approx_prod(approx_prod), .busy(s_busy), .done(s_done),
    .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
    .sum_abs_err(s_sum_abs_err), .max_abs_err(s_max_abs_err), .sat(s_sat)
`ifdef ERR_MON_WORST_CAPTURE_EN
    , .worst_a(s_worst_a), .worst_b(s_worst_b), .worst_approx(s_worst_approx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold one sample on the inputs until it is accepted (bounded wait).
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [PW-1:0] p);
    int n;
    op_a = a; op_b = b; approx_prod = p; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check("send_timeout_in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("wait_done_timeout", 64'(done), 64'(1));
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    start = 1'b1; num_samples = n;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic [5:0] vpat;
    int accepted;

    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    op_a = '0; op_b = '0; approx_prod = '0;
    step(); step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_in_ready",   64'(in_ready),    64'(0));
    check("rst_busy",       64'(busy),        64'(0));
    check("rst_done",       64'(done),        64'(0));
    check("rst_sample_cnt", 64'(sample_cnt),  64'(0));
    check("rst_err_cnt",    64'(err_cnt),     64'(0));
    check("rst_sum",        64'(sum_abs_err), 64'(0));
    check("rst_max",        64'(max_abs_err), 64'(0));
    check("rst_sat",        64'(sat),         64'(0));

    // Zero target from IDLE: DONE on the next edge, in_ready never rises.
    pulse_start(CNT_W'(0));
    check("zero_done",       64'(done),        64'(1));
    check("zero_busy",       64'(busy),        64'(0));
    check("zero_in_ready",   64'(in_ready),    64'(0));
    check("zero_sample_cnt", 64'(sample_cnt),  64'(0));
    check("zero_sum",        64'(sum_abs_err), 64'(0));
    step();
    check("zero_in_ready_2", 64'(in_ready),    64'(0));

    // Exact sample: 200*150 = 30000.
    pulse_start(CNT_W'(1));
    check("t1_done_cleared", 64'(done),     64'(0));
    check("t1_busy",         64'(busy),     64'(1));
    check("t1_in_ready",     64'(in_ready), 64'(1));
    send(8'd200, 8'd150, 16'd30000);
    wait_done();
    check("t1_sample_cnt", 64'(sample_cnt),  64'(1));
    check("t1_err_cnt",    64'(err_cnt),     64'(0));
    check("t1_sum",        64'(sum_abs_err), 64'(0));
    check("t1_max",        64'(max_abs_err), 64'(0));
    check("t1_sat",        64'(sat),         64'(0));
    check("t1_busy_low",   64'(busy),        64'(0));

    // Under-estimate 65025-65000=25, over-estimate 20-12=8, back to back.
    pulse_start(CNT_W'(2));
    send(8'd255, 8'd255, 16'd65000);
    send(8'd3, 8'd4, 16'd20);
    check("t2_in_ready_drain", 64'(in_ready), 64'(0));
    check("t2_busy_drain",     64'(busy),     64'(1));
    step();
    check("t2_cnt_first",  64'(sample_cnt), 64'(1));
    check("t2_done_early", 64'(done),       64'(0));
    step();
    check("t2_cnt_second",  64'(sample_cnt), 64'(2));
    check("t2_done_early2", 64'(done),       64'(0));
    step();
    check("t2_done",    64'(done),        64'(1));
    check("t2_sum",     64'(sum_abs_err), 64'(33));
    check("t2_max",     64'(max_abs_err), 64'(25));
    check("t2_err_cnt", 64'(err_cnt),     64'(2));
    check("t2_sat8_sum", 64'(s_sum_abs_err), 64'(33));
`ifdef ERR_MON_WORST_CAPTURE_EN
    check("t2_worst_a",      64'(worst_a),      64'(255));
    check("t2_worst_b",      64'(worst_b),      64'(255));
    check("t2_worst_approx", 64'(worst_approx), 64'(65000));
`endif

    // Saturation: |100-300| = 200, |0-200| = 200. ACC_W=8 clips at 255.
    pulse_start(CNT_W'(2));
    send(8'd10, 8'd10, 16'd300);
    send(8'd0, 8'd0, 16'd200);
    wait_done();
    check("t4_sat8_sum", 64'(s_sum_abs_err), 64'(255));
    check("t4_sat8_sat", 64'(s_sat),         64'(1));
    check("t4_sat8_max", 64'(s_max_abs_err), 64'(200));
    check("t4_sum32",    64'(sum_abs_err),   64'(400));
    check("t4_sat32",    64'(sat),           64'(0));

    // Flow control with in_valid gaps and start pulsed mid-run.
    // Each sample 5*5 = 25 against 20 gives |err| = 5.
    pulse_start(CNT_W'(4));
    check("t5_sat8_cleared", 64'(s_sat), 64'(0));
    vpat = 6'b101101;   // in_valid per cycle, bit 0 first: 1,0,1,1,0,1
    accepted = 0;
    op_a = 8'd5; op_b = 8'd5; approx_prod = 16'd20;
    for (int i = 0; i < 6; i++) begin
      in_valid = vpat[i];
      start = (i == 2);
      num_samples = (i == 2) ? CNT_W'(9) : CNT_W'(4);
      if (in_valid && in_ready) accepted++;
      step();
    end
    start = 1'b0;
    check("t5_in_ready_after_4", 64'(in_ready), 64'(0));
    check("t5_accepted",         64'(accepted), 64'(4));
    check("t5_busy",             64'(busy),     64'(1));
    step();   // in_valid still high: must not be taken
    in_valid = 1'b0;
    wait_done();
    check("t5_sample_cnt", 64'(sample_cnt),  64'(4));
    check("t5_err_cnt",    64'(err_cnt),     64'(4));
    check("t5_sum",        64'(sum_abs_err), 64'(20));
    check("t5_max",        64'(max_abs_err), 64'(5));

    // Reset mid-run after 2 of 5 accepted.
    pulse_start(CNT_W'(5));
    send(8'd7, 8'd7, 16'd40);
    send(8'd1, 8'd2, 16'd3);
    rst = 1'b1;
    step();
    check("t6_in_ready",   64'(in_ready),    64'(0));
    check("t6_busy",       64'(busy),        64'(0));
    check("t6_done",       64'(done),        64'(0));
    check("t6_sample_cnt", 64'(sample_cnt),  64'(0));
    check("t6_err_cnt",    64'(err_cnt),     64'(0));
    check("t6_sum",        64'(sum_abs_err), 64'(0));
    check("t6_max",        64'(max_abs_err), 64'(0));
    check("t6_sat",        64'(sat),         64'(0));
    rst = 1'b0;
    step(); step(); step();
    check("t6_no_residue", 64'(sample_cnt), 64'(0));
    check("t6_idle_ready", 64'(in_ready),   64'(0));
    pulse_start(CNT_W'(1));
    send(8'd9, 8'd9, 16'd81);
    wait_done();
    check("t6_rerun_cnt",  64'(sample_cnt),  64'(1));
    check("t6_rerun_err",  64'(err_cnt),     64'(0));
    check("t6_rerun_done", 64'(done),        64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
